// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4+ATOP subordinate backed by on-chip storage, one burst in flight at a time.
package axi_sram_responder_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module axi_sram_responder #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned MemBytes  = 4096,
  parameter type axi_req_t = axi_sram_responder_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_sram_responder_pkg::axi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  axi_req_t    axi_req_i,
  output axi_rsp_t    axi_rsp_o,
  output logic [15:0] err_cnt_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned LgStrb    = $clog2(StrbWidth);
  localparam int unsigned MemAw     = $clog2(MemBytes);
  localparam int unsigned Words     = MemBytes / StrbWidth;
  localparam logic [2:0] MaxSize    = 3'(LgStrb);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [AddrWidth-1:0] One = 1;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  state_e               r_state;
  logic [IdWidth-1:0]   r_id;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len, r_cnt;
  logic [2:0]           r_size;
  logic [1:0]           r_burst, r_bresp;
  logic                 r_atop, r_atop_rd, r_rr_wr;
  logic [15:0]          r_err_cnt;
  logic [DataWidth-1:0] r_mem [Words];

  logic                   w_idle, w_aw_rdy, w_ar_rdy, w_w_rdy, w_b_vld, w_r_vld;
  logic                   w_wh, w_bh, w_rh, w_err_inc, w_unused;
  logic [1:0]             w_status, w_r_resp;
  logic [MemAw-LgStrb-1:0] w_idx;
  logic [AddrWidth-1:0]   w_step, w_next;
  logic [DataWidth-1:0]   w_r_data;

  assign w_unused = ^axi_req_i;

  // Round-robin: r_rr_wr prefers write when AW and AR contend in IDLE
  assign w_idle   = !rst_i && r_state == IDLE;
  assign w_aw_rdy = w_idle && axi_req_i.aw_valid && (r_rr_wr || !axi_req_i.ar_valid);
  assign w_ar_rdy = w_idle && axi_req_i.ar_valid && (!r_rr_wr || !axi_req_i.aw_valid);
  assign w_w_rdy  = !rst_i && r_state == WRITE;
  assign w_b_vld  = !rst_i && r_state == WRESP;
  assign w_r_vld  = !rst_i && r_state == READ;
  assign w_wh     = w_w_rdy && axi_req_i.w_valid;
  assign w_bh     = w_b_vld && axi_req_i.b_ready;
  assign w_rh     = w_r_vld && axi_req_i.r_ready;

  assign w_idx    = r_addr[MemAw-1:LgStrb];
  assign w_status = (r_burst == BurstWrap || r_size > MaxSize) ? RespSlverr :
                    (|r_addr[AddrWidth-1:MemAw]) ? RespDecerr : RespOkay;
  assign w_r_resp = r_atop ? RespSlverr : w_status;
  assign w_r_data = w_r_resp == RespOkay ? r_mem[w_idx] : '0;
  assign w_step   = One << r_size;
  assign w_next   = r_burst == BurstFixed ? r_addr : (r_addr & ~(w_step - One)) + w_step;
  assign w_err_inc = (w_bh && r_bresp != RespOkay) || (w_rh && w_r_resp != RespOkay);
  assign err_cnt_o = r_err_cnt;

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = w_aw_rdy;
    axi_rsp_o.ar_ready = w_ar_rdy;
    axi_rsp_o.w_ready  = w_w_rdy;
    axi_rsp_o.b_valid  = w_b_vld;
    axi_rsp_o.b.id     = r_id;
    axi_rsp_o.b.resp   = r_bresp;
    axi_rsp_o.r_valid  = w_r_vld;
    axi_rsp_o.r.id     = r_id;
    axi_rsp_o.r.data   = w_r_data;
    axi_rsp_o.r.resp   = w_r_resp;
    axi_rsp_o.r.last   = r_cnt == r_len;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_rr_wr   <= 1'b1;
      r_err_cnt <= '0;
    end else begin
      if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      case (r_state)
        IDLE: begin
          if (w_aw_rdy) begin
            r_id      <= axi_req_i.aw.id;
            r_addr    <= axi_req_i.aw.addr;
            r_len     <= axi_req_i.aw.len;
            r_size    <= axi_req_i.aw.size;
            r_burst   <= axi_req_i.aw.burst;
            r_atop    <= |axi_req_i.aw.atop;
            r_atop_rd <= axi_req_i.aw.atop[5];
            r_bresp   <= |axi_req_i.aw.atop ? RespSlverr : RespOkay;
            r_rr_wr   <= 1'b0;
            r_state   <= WRITE;
          end else if (w_ar_rdy) begin
            r_id      <= axi_req_i.ar.id;
            r_addr    <= axi_req_i.ar.addr;
            r_len     <= axi_req_i.ar.len;
            r_size    <= axi_req_i.ar.size;
            r_burst   <= axi_req_i.ar.burst;
            r_atop    <= 1'b0;
            r_atop_rd <= 1'b0;
            r_cnt     <= '0;
            r_rr_wr   <= 1'b1;
            r_state   <= READ;
          end
        end
        WRITE: begin
          if (w_wh) begin
            r_addr <= w_next;
            if (!r_atop && w_status > r_bresp) r_bresp <= w_status;
            if (axi_req_i.w.last) r_state <= WRESP;
          end
        end
        WRESP: begin
          if (w_bh) begin
            r_cnt   <= '0;
            r_state <= r_atop_rd ? READ : IDLE;
          end
        end
        READ: begin
          if (w_rh) begin
            r_addr <= w_next;
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == r_len) r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Storage has no reset; atomics and erroring beats never touch it
  always_ff @(posedge clk_i) begin
    if (w_wh && !r_atop && w_status == RespOkay)
      for (int i = 0; i < StrbWidth; i++)
        if (axi_req_i.w.strb[i]) r_mem[w_idx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
  end
endmodule
